// File: rtl/serial_twos_pkg.sv
// -----------------------------------------------------------------------------
// serial_twos_pkg
// Shared definitions for the bit-serial two's-complement negator:
//   - operand mode encodings (pass / negate / absolute value)
//   - FSM state encoding for the sequencer
//   - is_min_neg(): recognises the most negative value of a given width
//     (the only operand whose negation overflows)
// -----------------------------------------------------------------------------
package serial_twos_pkg;

    localparam logic [1:0] MODE_PASS = 2'b00;
    localparam logic [1:0] MODE_NEG  = 2'b01;
    localparam logic [1:0] MODE_ABS  = 2'b10;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    // True when the low 'width' bits of 'value' are 100...0.
    function automatic logic is_min_neg(input logic [63:0] value,
                                        input int unsigned width);
        logic [63:0] mask;
        logic [63:0] min_val;
        mask    = (width >= 64) ? '1 : ((64'd1 << width) - 64'd1);
        min_val = 64'd1 << (width - 1);
        return (value & mask) == min_val;
    endfunction

endpackage

// File: rtl/serial_twos_bit_cell.sv
// -----------------------------------------------------------------------------
// serial_twos_bit_cell
// One-bit slice of a serial two's-complement negator. Bits arrive LSB first;
// once the first '1' has passed, every later bit is inverted when negation is
// enabled (the classic "copy up to and including the first one, then flip").
//
// Ports:
//   clk, reset  : clock, synchronous active-high reset
//   b           : incoming serial bit
//   neg_en      : 1 = negate the stream, 0 = pass it through
//   clear       : restart the stream (clears found_one)
//   en          : advance one bit this cycle
//   ser_bit     : processed bit (combinational)
//   found_one   : a '1' has been seen on an earlier bit of this stream
// -----------------------------------------------------------------------------
module serial_twos_bit_cell (
    input  logic clk,
    input  logic reset,
    input  logic b,
    input  logic neg_en,
    input  logic clear,
    input  logic en,
    output logic ser_bit,
    output logic found_one
);

    // NOTE: clocked state uses non-blocking assignments so every flop samples
    // pre-edge values regardless of block ordering.
    always_ff @(posedge clk) begin
        if (reset || clear) begin
            found_one <= 1'b0;
        end else if (en) begin
            found_one <= found_one | b;
        end
    end

    // The current bit is compared against found_one from earlier bits only,
    // so the first '1' itself is copied unchanged.
    assign ser_bit = (neg_en && found_one) ? ~b : b;

endmodule

// File: rtl/serial_twos_negator.sv
// -----------------------------------------------------------------------------
// serial_twos_negator
// Bit-serial two's-complement unit: pass, negate or absolute value of a
// WIDTH-bit signed operand, processed LSB first over WIDTH cycles.
//
// Ports:
//   clk, reset  : clock, synchronous active-high reset
//   start       : load din/mode (accepted only while in_ready)
//   din         : signed operand
//   mode        : 00 pass, 01 negate, 10 abs, 11 pass
//   in_ready    : idle, able to accept start
//   busy        : shifting or holding a result
//   ser_bit     : processed bit of the current shift cycle, LSB first
//   ser_valid   : ser_bit is meaningful (exactly WIDTH cycles per operand)
//   dout        : result, valid while done; held until the next acceptance
//   done        : result available
//   out_ready   : consumer acknowledge; releases DONE
//   overflow    : negate/abs applied to the most negative value
// -----------------------------------------------------------------------------
module serial_twos_negator
    import serial_twos_pkg::*;
#(
    parameter  int WIDTH = 16,
    localparam int CNT_W = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] din,
    input  logic [1:0]       mode,
    output logic             in_ready,
    output logic             busy,
    output logic             ser_bit,
    output logic             ser_valid,
    output logic [WIDTH-1:0] dout,
    output logic             done,
    input  logic             out_ready,
    output logic             overflow
);

    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

    state_t             state;
    logic [WIDTH-1:0]   shreg;
    logic [CNT_W-1:0]   cnt;
    logic               neg_en;
    logic               sign_in;
    logic               cell_bit;
    logic               found_one;
    logic               accept;
    logic               shifting;
    logic [WIDTH-1:0]   rotated;

    assign accept   = (state == S_IDLE) && start;
    assign shifting = (state == S_SHIFT);

    serial_twos_bit_cell u_cell (
        .clk       (clk),
        .reset     (reset),
        .b         (shreg[0]),
        .neg_en    (neg_en),
        .clear     (accept),
        .en        (shifting),
        .ser_bit   (cell_bit),
        .found_one (found_one)
    );

    // Processed bit re-enters at the top; after WIDTH rotations the register
    // holds the complete, bit-aligned result.
    assign rotated = {cell_bit, shreg[WIDTH-1:1]};

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= S_IDLE;
            shreg   <= '0;
            cnt     <= '0;
            neg_en  <= 1'b0;
            sign_in <= 1'b0;
            dout    <= '0;
            overflow <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        shreg   <= din;
                        neg_en  <= (mode == MODE_NEG) ||
                                   ((mode == MODE_ABS) && din[WIDTH-1]);
                        sign_in <= din[WIDTH-1];
                        cnt     <= '0;
                        state   <= S_SHIFT;
                    end
                end
                S_SHIFT: begin
                    shreg <= rotated;
                    if (cnt == LAST_BIT) begin
                        dout <= rotated;
                        // Negating 100...0 yields itself: a negative input
                        // with a negative result is the only overflow case.
                        overflow <= neg_en && sign_in && cell_bit;
                        state    <= S_DONE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                S_DONE: begin
                    if (out_ready) begin
                        state <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign in_ready  = (state == S_IDLE);
    assign busy      = (state == S_SHIFT) || (state == S_DONE);
    assign done      = (state == S_DONE);
    assign ser_valid = shifting;
    assign ser_bit   = shifting && cell_bit;

endmodule

// File: tb/tb_serial_twos_negator.sv
// -----------------------------------------------------------------------------
// tb_serial_twos_negator
// Three instances (WIDTH = 16, 4, 32) driven on the falling edge and sampled
// on the falling edge. Expected results come from plain modular arithmetic.
// -----------------------------------------------------------------------------
module tb_serial_twos_negator;
    import serial_twos_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic [2:0]  start_v;
    logic [63:0] din_v [3];
    logic [1:0]  mode_v [3];
    logic [2:0]  out_ready_v;
    logic [2:0]  in_ready_v, busy_v, ser_bit_v, ser_valid_v, done_v, overflow_v;
    logic [15:0] dout16;
    logic [3:0]  dout4;
    logic [31:0] dout32;
    logic [63:0] dout_v [3];

    int n_cmp  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    assign dout_v[0] = 64'(dout16);
    assign dout_v[1] = 64'(dout4);
    assign dout_v[2] = 64'(dout32);

    serial_twos_negator #(.WIDTH(16)) u_dut16 (
        .clk(clk), .reset(reset), .start(start_v[0]), .din(din_v[0][15:0]),
        .mode(mode_v[0]), .in_ready(in_ready_v[0]), .busy(busy_v[0]),
        .ser_bit(ser_bit_v[0]), .ser_valid(ser_valid_v[0]), .dout(dout16),
        .done(done_v[0]), .out_ready(out_ready_v[0]), .overflow(overflow_v[0]));

    serial_twos_negator #(.WIDTH(4)) u_dut4 (
        .clk(clk), .reset(reset), .start(start_v[1]), .din(din_v[1][3:0]),
        .mode(mode_v[1]), .in_ready(in_ready_v[1]), .busy(busy_v[1]),
        .ser_bit(ser_bit_v[1]), .ser_valid(ser_valid_v[1]), .dout(dout4),
        .done(done_v[1]), .out_ready(out_ready_v[1]), .overflow(overflow_v[1]));

    serial_twos_negator #(.WIDTH(32)) u_dut32 (
        .clk(clk), .reset(reset), .start(start_v[2]), .din(din_v[2][31:0]),
        .mode(mode_v[2]), .in_ready(in_ready_v[2]), .busy(busy_v[2]),
        .ser_bit(ser_bit_v[2]), .ser_valid(ser_valid_v[2]), .dout(dout32),
        .done(done_v[2]), .out_ready(out_ready_v[2]), .overflow(overflow_v[2]));

    function automatic int width_of(input int k);
        case (k)
            0:       return 16;
            1:       return 4;
            default: return 32;
        endcase
    endfunction

    function automatic logic [63:0] mask_of(input int w);
        return (w >= 64) ? '1 : ((64'd1 << w) - 64'd1);
    endfunction

    // Reference: pass = x, negate = -x mod 2^w, abs = |x| mod 2^w.
    function automatic logic [63:0] ref_result(input logic [63:0] din,
                                               input logic [1:0] mode,
                                               input int w);
        logic [63:0] x;
        logic        is_neg;
        x      = din & mask_of(w);
        is_neg = x[w-1];
        case (mode)
            MODE_NEG: return (64'd0 - x) & mask_of(w);
            MODE_ABS: return is_neg ? ((64'd0 - x) & mask_of(w)) : x;
            default:  return x;
        endcase
    endfunction

    function automatic logic ref_overflow(input logic [63:0] din,
                                          input logic [1:0] mode,
                                          input int w);
        logic [63:0] x;
        x = din & mask_of(w);
        return ((mode == MODE_NEG) || ((mode == MODE_ABS) && x[w-1])) &&
               is_min_neg(x, w);
    endfunction

    task automatic check(input string tag, input logic [63:0] obs,
                         input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One full transaction on instance k. poke_at >= 0 pulses start (with a
    // different operand) at that shift cycle; start_on_release raises start
    // together with out_ready in DONE. Both must be ignored.
    task automatic run_op(input int k, input logic [63:0] din,
                          input logic [1:0] mode, input int hold,
                          input int poke_at, input bit start_on_release,
                          input string tag);
        int          w;
        int          edges;
        int          nbits;
        logic [63:0] exp;
        logic [63:0] stream;
        w      = width_of(k);
        exp    = ref_result(din, mode, w);
        stream = '0;
        nbits  = 0;

        check({tag, ".in_ready"}, 64'(in_ready_v[k]), 64'd1);
        start_v[k] = 1'b1;
        din_v[k]   = din;
        mode_v[k]  = mode;
        @(negedge clk);
        start_v[k] = 1'b0;
        din_v[k]   = {$urandom, $urandom};
        mode_v[k]  = 2'($urandom_range(0, 3));
        edges      = 1;

        while (!done_v[k] && edges < w + 20) begin
            if (ser_valid_v[k]) begin
                stream[nbits] = ser_bit_v[k];
                nbits++;
            end
            if (nbits == poke_at) begin
                start_v[k] = 1'b1;
                din_v[k]   = 64'h1111;
            end else begin
                start_v[k] = 1'b0;
            end
            @(negedge clk);
            edges++;
        end
        start_v[k] = 1'b0;

        check({tag, ".latency"}, 64'(edges), 64'(w + 1));
        check({tag, ".nbits"}, 64'(nbits), 64'(w));
        check({tag, ".stream"}, stream, exp);
        check({tag, ".dout"}, dout_v[k], exp);
        check({tag, ".overflow"}, 64'(overflow_v[k]), 64'(ref_overflow(din, mode, w)));
        check({tag, ".busy_in_ready"}, 64'({busy_v[k], in_ready_v[k]}), 64'b10);

        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            check({tag, ".hold"}, {done_v[k], in_ready_v[k], dout_v[k][61:0]},
                  {1'b1, 1'b0, exp[61:0]});
        end

        out_ready_v[k] = 1'b1;
        if (start_on_release) begin
            start_v[k] = 1'b1;
            din_v[k]   = 64'h1111;
            mode_v[k]  = MODE_NEG;
        end
        @(negedge clk);
        out_ready_v[k] = 1'b0;
        start_v[k]     = 1'b0;
        check({tag, ".release"},
              64'({done_v[k], in_ready_v[k], busy_v[k], ser_valid_v[k]}), 64'b0100);
        check({tag, ".retained"}, dout_v[k], exp);
    endtask

    initial begin
        logic [63:0] rdin;
        int          k;

        reset       = 1'b1;
        start_v     = '0;
        out_ready_v = '0;
        for (int i = 0; i < 3; i++) begin
            din_v[i]  = '0;
            mode_v[i] = '0;
        end
        repeat (3) @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            check($sformatf("reset%0d.flags", i),
                  64'({in_ready_v[i], busy_v[i], done_v[i], ser_valid_v[i], overflow_v[i]}),
                  64'b10000);
            check($sformatf("reset%0d.dout", i), dout_v[i], 64'd0);
        end
        reset = 1'b0;
        @(negedge clk);

        // Directed WIDTH=16 cases.
        run_op(0, 64'h0005, MODE_NEG, 5, 3, 1'b1, "neg5");
        run_op(0, 64'h8000, MODE_NEG, 0, -1, 1'b0, "negmin");
        run_op(0, 64'h8000, MODE_PASS, 0, -1, 1'b0, "passmin");
        run_op(0, 64'hFF38, MODE_ABS, 1, -1, 1'b0, "absneg");
        run_op(0, 64'h00C8, MODE_ABS, 0, -1, 1'b0, "abspos");
        run_op(0, 64'h0000, MODE_NEG, 0, -1, 1'b0, "negzero");
        run_op(0, 64'h1234, 2'b11, 0, -1, 1'b0, "mode11");
        run_op(0, 64'h8000, MODE_ABS, 0, -1, 1'b0, "absmin");

        // Reset during shift cycle 7.
        start_v[0] = 1'b1;
        din_v[0]   = 64'h0005;
        mode_v[0]  = MODE_NEG;
        @(negedge clk);
        start_v[0] = 1'b0;
        repeat (7) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("midreset.flags",
              64'({in_ready_v[0], busy_v[0], done_v[0], ser_valid_v[0], overflow_v[0]}),
              64'b10000);
        check("midreset.dout", dout_v[0], 64'd0);
        run_op(0, 64'h0001, MODE_NEG, 0, -1, 1'b0, "after_reset");

        // Boundary operands on the other widths.
        run_op(1, 64'h8, MODE_NEG, 0, -1, 1'b0, "w4_negmin");
        run_op(1, 64'h7, MODE_ABS, 0, -1, 1'b0, "w4_abspos");
        run_op(2, 64'h8000_0000, MODE_ABS, 0, -1, 1'b0, "w32_absmin");
        run_op(2, 64'hFFFF_FFFF, MODE_NEG, 0, -1, 1'b0, "w32_negm1");

        // Randomised sweep on WIDTH=4 and WIDTH=32.
        for (int i = 0; i < 40; i++) begin
            k    = (i % 2 == 0) ? 1 : 2;
            rdin = {$urandom, $urandom} & mask_of(width_of(k));
            run_op(k, rdin, 2'($urandom_range(0, 3)), $urandom_range(0, 2),
                   -1, 1'($urandom_range(0, 1)), $sformatf("rand%0d_w%0d", i, width_of(k)));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
